// File: rtl/cdl_pkg.sv
// cdl_pkg: shared receiver types, byte-group lengths and state helpers
package cdl_pkg;
  typedef enum logic [1:0] {B8_1 = 2'd0, B8_2 = 2'd1, B9 = 2'd2, IDLE = 2'd3} rcv_state_t;
  localparam logic [3:0] B8_LEN = 4'd8;
  localparam logic [3:0] B9_LEN = 4'd9;
  function automatic logic [3:0] last_bit(input rcv_state_t s);
    return s == B9 ? B9_LEN - 4'd1 : B8_LEN - 4'd1;
  endfunction
  function automatic rcv_state_t next_byte(input rcv_state_t s);
    return s == B8_1 ? B8_2 : s == B8_2 ? B9 : B8_1;
  endfunction
endpackage

// File: rtl/flex_counter.sv
// flex_counter: rollover counter running 1..rollover_val; clear restarts at 1 when enabled, else 0
module flex_counter #(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag
);
  assign rollover_flag = count_out == rollover_val;
  always_ff @(posedge clk)
    if (!n_rst) count_out <= '0;
    else if (clear) count_out <= {{(NUM_CNT_BITS-1){1'b0}}, count_enable};
    else if (count_enable) count_out <= rollover_flag ? {{(NUM_CNT_BITS-1){1'b0}}, 1'b1} : count_out + {{(NUM_CNT_BITS-1){1'b0}}, 1'b1};
endmodule

// File: rtl/rcv_bit_timer.sv
// rcv_bit_timer: bit/byte strobe timing for 8,8,9-bit byte groups; RCV_RESYNC_EN enables edge resync
module rcv_bit_timer
  import cdl_pkg::*;
#(
  parameter int BIT_PERIOD   = 8,
  parameter int SAMPLE_PHASE = 4
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  output logic       shift_strobe,
  output logic       pad_strobe,
  output logic       byte_received,
  output logic [1:0] byte_phase,
  output logic [3:0] bit_index
);
  localparam logic [3:0] BP = 4'(BIT_PERIOD);
  localparam logic [3:0] SP = 4'(SAMPLE_PHASE);
  rcv_state_t state, nxt_state;
  logic [3:0] nxt_index, cnt;
  logic clear, cnt_en, wrap, active, strobe, early, late, advance, at_last;
  flex_counter #(.NUM_CNT_BITS(4)) u_cnt (
    .clk(clk),
    .n_rst(n_rst),
    .clear(clear),
    .count_enable(cnt_en),
    .rollover_val(BP),
    .count_out(cnt),
    .rollover_flag(wrap)
  );
`ifdef RCV_RESYNC_EN
  assign early = d_edge && cnt > SP && cnt < BP;
  assign late  = d_edge && cnt < SP;
`else
  assign early = 1'b0;
  assign late  = 1'b0;
`endif
  assign active  = state != IDLE;
  assign advance = wrap || early;
  assign at_last = bit_index == last_bit(state);
  always_comb begin
    nxt_state = state;
    nxt_index = bit_index;
    clear     = 1'b0;
    cnt_en    = 1'b0;
    if (!active || !rcving) begin
      clear     = 1'b1;
      nxt_index = '0;
      cnt_en    = !active && rcving && d_edge;
      nxt_state = cnt_en ? B8_1 : IDLE;
    end else begin
      cnt_en    = 1'b1;
      clear     = early || late;
      nxt_index = advance ? (at_last ? 4'd0 : bit_index + 4'd1) : bit_index;
      nxt_state = advance && at_last ? next_byte(state) : state;
    end
  end
  always_ff @(posedge clk)
    if (!n_rst) begin
      state     <= IDLE;
      bit_index <= '0;
    end else begin
      state     <= nxt_state;
      bit_index <= nxt_index;
    end
  // strobes come purely from registered state so a falling rcving cannot cut one short
  assign strobe        = active && cnt == SP;
  assign shift_strobe  = strobe && bit_index < 4'd8;
  assign pad_strobe    = strobe && state == B9 && bit_index == 4'd8;
  assign byte_received = strobe && at_last;
  assign byte_phase    = active ? state : 2'd0;
endmodule
